uart_tx_sched: RTL and testbench

- Scheduler that shares one UART transmitter between two transmit FIFOs: channel 0 for CPU data, channel 1 for echo/status.
- Pops one word at a time from the granted FIFO, hands it to the transmitter with a start/done handshake, then enforces a programmable inter-frame gap.
- Sits between the two FIFO read ports and the UART TX core.

---
 rtl/uart_tx_sched.sv | 139 +++++++++++++
 tb/tb_uart_tx_sched.sv | 339 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_tx_sched.sv
// ---------------------------------------------------------------------------
// uart_tx_sched
//   Shares one UART transmitter between two transmit FIFOs. Channel 0 carries
//   CPU data, channel 1 carries echo/status. One word at a time is popped from
//   the granted FIFO, handed to the transmitter with a start/done handshake,
//   and followed by a programmable inter-frame gap.
//
// Ports
//   clk          : system clock, rising edge
//   reset        : asynchronous, active-low reset
//   en           : 1 = may start new frames; 0 = finish current frame only
//   gap_cycles   : idle cycles inserted after each tx_done_tick (0 = none)
//   empty0/1     : FIFO empty flags
//   r_data0/1    : FIFO head words (valid while not empty)
//   rd0/rd1      : FIFO pop strobes (combinational, issued in IDLE)
//   tx_start     : one-cycle start pulse to the transmitter
//   tx_din       : word being transmitted
//   tx_done_tick : one-cycle pulse from the transmitter at end of stop bit
//   busy         : high in every state except IDLE
//   grant        : channel of the frame in flight, or the last one served
//   sent_count   : completed frames, wraps modulo 2^CNT_WIDTH
// ---------------------------------------------------------------------------
module uart_tx_sched #(
    parameter int unsigned DATA_WIDTH = 8,
    parameter int unsigned GAP_WIDTH  = 8,
    parameter int unsigned CNT_WIDTH  = 16
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  en,
    input  logic [GAP_WIDTH-1:0]  gap_cycles,
    input  logic                  empty0,
    input  logic [DATA_WIDTH-1:0] r_data0,
    output logic                  rd0,
    input  logic                  empty1,
    input  logic [DATA_WIDTH-1:0] r_data1,
    output logic                  rd1,
    output logic                  tx_start,
    output logic [DATA_WIDTH-1:0] tx_din,
    input  logic                  tx_done_tick,
    output logic                  busy,
    output logic                  grant,
    output logic [CNT_WIDTH-1:0]  sent_count
);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_START = 2'd1,
        S_WAIT  = 2'd2,
        S_GAP   = 2'd3
    } state_t;

    state_t                state_q, state_d;
    logic [DATA_WIDTH-1:0] tx_din_q, tx_din_d;
    logic                  grant_q, grant_d;
    logic [GAP_WIDTH-1:0]  gap_q, gap_d;
    logic [CNT_WIDTH-1:0]  cnt_q, cnt_d;
    logic                  busy_q;
    logic                  sel;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q  <= S_IDLE;
            tx_din_q <= '0;
            grant_q  <= 1'b1;   // channel 0 wins the first contention
            gap_q    <= '0;
            cnt_q    <= '0;
            busy_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            tx_din_q <= tx_din_d;
            grant_q  <= grant_d;
            gap_q    <= gap_d;
            cnt_q    <= cnt_d;
            // Registering the next-state decode makes busy track state_q.
            busy_q   <= (state_d != S_IDLE);
        end
    end

    always_comb begin
        state_d  = state_q;
        tx_din_d = tx_din_q;
        grant_d  = grant_q;
        gap_d    = gap_q;
        cnt_d    = cnt_q;
        rd0      = 1'b0;
        rd1      = 1'b0;
        sel      = 1'b0;

        case (state_q)
            S_IDLE: begin
                // The pop strobe is Mealy, so it is also gated by reset to
                // keep the FIFOs untouched while reset is held.
                if (reset && en && (!empty0 || !empty1)) begin
                    if (!empty0 && !empty1) begin
                        sel = ~grant_q;     // round-robin on contention
                    end else begin
                        sel = empty0;       // the only non-empty channel
                    end
                    rd0      = ~sel;
                    rd1      = sel;
                    tx_din_d = sel ? r_data1 : r_data0;
                    grant_d  = sel;
                    state_d  = S_START;
                end
            end
            S_START: begin
                state_d = S_WAIT;
            end
            S_WAIT: begin
                if (tx_done_tick) begin
                    cnt_d = cnt_q + CNT_WIDTH'(1);
                    if (gap_cycles == '0) begin
                        state_d = S_IDLE;
                    end else begin
                        gap_d   = gap_cycles;
                        state_d = S_GAP;
                    end
                end
            end
            S_GAP: begin
                gap_d = gap_q - GAP_WIDTH'(1);
                if (gap_q == GAP_WIDTH'(1)) begin
                    state_d = S_IDLE;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    assign tx_start   = (state_q == S_START);
    assign tx_din     = tx_din_q;
    assign busy       = busy_q;
    assign grant      = grant_q;
    assign sent_count = cnt_q;

endmodule

// File: tb/tb_uart_tx_sched.sv
// ---------------------------------------------------------------------------
// tb_uart_tx_sched
//   Directed bench for uart_tx_sched: behavioural FIFOs, a transmitter model
//   that answers tx_start with tx_done_tick after tx_len cycles, a frame table
//   for arbitration order, and hand-written sequences for gap, enable, reset
//   and counter wrap. A second instance with a 4-bit counter sees the same
//   inputs so wrap-around is reached within a short run.
// ---------------------------------------------------------------------------
module tb_uart_tx_sched;

    logic        clk = 1'b0;
    always #5 clk = ~clk;

    logic        reset;
    logic        en;
    logic [7:0]  gap_cycles;
    logic        empty0, empty1;
    logic [7:0]  r_data0, r_data1;
    logic        rd0, rd1, tx_start, busy, grant;
    logic [7:0]  tx_din;
    logic        tx_done_tick;
    logic [15:0] sent_count;

    logic        rd0_w, rd1_w, tx_start_w, busy_w, grant_w;
    logic [7:0]  tx_din_w;
    logic [3:0]  sent_count_w;

    uart_tx_sched #(.DATA_WIDTH(8), .GAP_WIDTH(8), .CNT_WIDTH(16)) u_dut (
        .clk(clk), .reset(reset), .en(en), .gap_cycles(gap_cycles),
        .empty0(empty0), .r_data0(r_data0), .rd0(rd0),
        .empty1(empty1), .r_data1(r_data1), .rd1(rd1),
        .tx_start(tx_start), .tx_din(tx_din), .tx_done_tick(tx_done_tick),
        .busy(busy), .grant(grant), .sent_count(sent_count)
    );

    uart_tx_sched #(.DATA_WIDTH(8), .GAP_WIDTH(8), .CNT_WIDTH(4)) u_dut_w (
        .clk(clk), .reset(reset), .en(en), .gap_cycles(gap_cycles),
        .empty0(empty0), .r_data0(r_data0), .rd0(rd0_w),
        .empty1(empty1), .r_data1(r_data1), .rd1(rd1_w),
        .tx_start(tx_start_w), .tx_din(tx_din_w), .tx_done_tick(tx_done_tick),
        .busy(busy_w), .grant(grant_w), .sent_count(sent_count_w)
    );

    // Behavioural FIFOs: pushed by the test, popped by the DUT strobes.
    logic [7:0] f0 [16];
    logic [7:0] f1 [16];
    int h0 = 0, t0 = 0, h1 = 0, t1 = 0;
    assign empty0  = (h0 == t0);
    assign empty1  = (h1 == t1);
    assign r_data0 = f0[h0[3:0]];
    assign r_data1 = f1[h1[3:0]];

    always @(posedge clk) begin
        if (rd0) h0 <= h0 + 1;
        if (rd1) h1 <= h1 + 1;
    end

    // Transmitter model.
    int   tx_len = 10;
    int   tx_cd  = 0;
    logic man_done = 1'b0;
    always @(posedge clk or negedge reset) begin
        if (!reset)          tx_cd <= 0;
        else if (tx_start)   tx_cd <= tx_len;
        else if (tx_cd != 0) tx_cd <= tx_cd - 1;
    end
    assign tx_done_tick = (tx_cd == 1) || man_done;

    // Cycle stamps, pop-rule monitor and event logs.
    int   cyc = 0;
    int   viol = 0;
    logic log_en = 1'b0;
    int   rd1_cyc [4];
    int   done_cyc [4];
    int   rd1_n = 0, done_n = 0;
    always @(posedge clk) begin
        cyc <= cyc + 1;
        if ((rd0 && rd1) || (rd0 && empty0) || (rd1 && empty1) ||
            (rd0_w !== rd0) || (rd1_w !== rd1) || (tx_start_w !== tx_start) ||
            (busy_w !== busy) || (grant_w !== grant) || (tx_din_w !== tx_din))
            viol <= viol + 1;
        if (log_en && rd1 && rd1_n < 4) begin
            rd1_cyc[rd1_n] <= cyc;
            rd1_n <= rd1_n + 1;
        end
        if (log_en && tx_done_tick && done_n < 4) begin
            done_cyc[done_n] <= cyc;
            done_n <= done_n + 1;
        end
    end

    int n_checks = 0;
    int n_errors = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(negedge clk);
        #1;
    endtask

    task automatic push0(input logic [7:0] d);
        f0[t0[3:0]] = d;
        t0 = t0 + 1;
    endtask

    task automatic push1(input logic [7:0] d);
        f1[t1[3:0]] = d;
        t1 = t1 + 1;
    endtask

    task automatic wait_start(input string name);
        logic got;
        got = 1'b0;
        for (int k = 0; k < 60 && !got; k++) begin
            tick();
            got = tx_start;
        end
        chk({name, "_start_seen"}, {31'd0, got}, 32'd1);
    endtask

    task automatic wait_idle(input string name);
        logic got;
        got = 1'b0;
        for (int k = 0; k < 80 && !got; k++) begin
            tick();
            got = ~busy;
        end
        chk({name, "_idle_seen"}, {31'd0, got}, 32'd1);
    endtask

    typedef struct {
        logic        p0;
        logic [7:0]  d0;
        logic        p1;
        logic [7:0]  d1;
        logic [7:0]  exp_din;
        logic        exp_grant;
        logic [15:0] exp_cnt;
    } vec_t;

    vec_t tbl [8];

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout, expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        int   act;
        int   bad;
        logic got;

        // Frame table, applied right after a reset (grant starts at 1).
        tbl[0] = '{1'b1, 8'h10, 1'b1, 8'h20, 8'h10, 1'b0, 16'd1};
        tbl[1] = '{1'b1, 8'h11, 1'b1, 8'h21, 8'h20, 1'b1, 16'd2};
        tbl[2] = '{1'b1, 8'h12, 1'b1, 8'h22, 8'h11, 1'b0, 16'd3};
        tbl[3] = '{1'b0, 8'h00, 1'b0, 8'h00, 8'h21, 1'b1, 16'd4};
        tbl[4] = '{1'b0, 8'h00, 1'b0, 8'h00, 8'h12, 1'b0, 16'd5};
        tbl[5] = '{1'b0, 8'h00, 1'b0, 8'h00, 8'h22, 1'b1, 16'd6};
        tbl[6] = '{1'b0, 8'h00, 1'b1, 8'h30, 8'h30, 1'b1, 16'd7};
        tbl[7] = '{1'b0, 8'h00, 1'b1, 8'h31, 8'h31, 1'b1, 16'd8};

        reset      = 1'b0;
        en         = 1'b1;
        gap_cycles = 8'd0;
        repeat (3) tick();
        chk("rst_busy",   {31'd0, busy},  32'd0);
        chk("rst_grant",  {31'd0, grant}, 32'd1);
        chk("rst_tx_din", {24'd0, tx_din}, 32'h00);
        chk("rst_count",  {16'd0, sent_count}, 32'd0);

        // Idle with both FIFOs empty.
        reset = 1'b1;
        act = 0;
        repeat (20) begin
            tick();
            if (rd0 || rd1 || tx_start || busy) act++;
        end
        chk("idle_activity", act, 0);
        chk("idle_count",  {16'd0, sent_count}, 32'd0);
        chk("idle_tx_din", {24'd0, tx_din}, 32'h00);

        // Single frame on channel 0, done 10 cycles after tx_start.
        push0(8'hA5);
        #1;
        chk("c0_rd0", {31'd0, rd0}, 32'd1);
        chk("c0_rd1", {31'd0, rd1}, 32'd0);
        tick();
        chk("c0_start", {31'd0, tx_start}, 32'd1);
        chk("c0_din",   {24'd0, tx_din}, 32'hA5);
        chk("c0_grant", {31'd0, grant}, 32'd0);
        chk("c0_busy",  {31'd0, busy}, 32'd1);
        tick();
        chk("c0_start_pulse", {31'd0, tx_start}, 32'd0);
        repeat (8) tick();
        chk("c0_count_before_done", {16'd0, sent_count}, 32'd0);
        tick();
        chk("c0_done_busy", {31'd0, busy}, 32'd1);
        tick();
        chk("c0_busy_fall", {31'd0, busy}, 32'd0);
        chk("c0_count",     {16'd0, sent_count}, 32'd1);
        chk("c0_din_hold",  {24'd0, tx_din}, 32'hA5);

        // Round-robin order from the frame table.
        reset = 1'b0;
        tick();
        reset = 1'b1;
        tx_len = 3;
        for (int i = 0; i < 8; i++) begin
            if (tbl[i].p0) push0(tbl[i].d0);
            if (tbl[i].p1) push1(tbl[i].d1);
            wait_start($sformatf("tbl%0d", i));
            chk($sformatf("tbl%0d_din", i),   {24'd0, tx_din}, {24'd0, tbl[i].exp_din});
            chk($sformatf("tbl%0d_grant", i), {31'd0, grant},  {31'd0, tbl[i].exp_grant});
            wait_idle($sformatf("tbl%0d", i));
            chk($sformatf("tbl%0d_count", i), {16'd0, sent_count}, {16'd0, tbl[i].exp_cnt});
        end

        // Inter-frame gap of 5 cycles on channel 1.
        gap_cycles = 8'd5;
        tx_len = 2;
        log_en = 1'b1;
        push1(8'h70);
        push1(8'h71);
        #1;
        chk("gap_rd1_first", {31'd0, rd1}, 32'd1);
        got = 1'b0;
        for (int k = 0; k < 20 && !got; k++) begin
            tick();
            got = tx_done_tick;
        end
        chk("gap_done_seen", {31'd0, got}, 32'd1);
        bad = 0;
        repeat (5) begin
            tick();
            if (!busy || rd0 || rd1) bad++;
        end
        chk("gap_quiet_busy", bad, 0);
        tick();
        chk("gap_rd1_second", {31'd0, rd1}, 32'd1);
        wait_start("gap2");
        chk("gap2_din", {24'd0, tx_din}, 32'h71);
        wait_idle("gap2");
        chk("gap_count", {16'd0, sent_count}, 32'd10);
        log_en = 1'b0;
        chk("gap_spacing", rd1_cyc[1] - done_cyc[0], 32'd6);

        // Enable dropped mid-frame.
        gap_cycles = 8'd0;
        tx_len = 6;
        push0(8'h40);
        push0(8'h41);
        wait_start("en1");
        chk("en1_din", {24'd0, tx_din}, 32'h40);
        tick();
        en = 1'b0;
        wait_idle("en1");
        chk("en1_count", {16'd0, sent_count}, 32'd11);
        act = 0;
        repeat (8) begin
            tick();
            if (rd0 || rd1 || tx_start || busy) act++;
        end
        chk("en_off_activity", act, 0);
        chk("en_off_pending", {31'd0, empty0}, 32'd0);
        en = 1'b1;
        #1;
        chk("en_on_rd0", {31'd0, rd0}, 32'd1);
        wait_start("en2");
        chk("en2_din", {24'd0, tx_din}, 32'h41);
        wait_idle("en2");
        chk("en2_count", {16'd0, sent_count}, 32'd12);

        // Reset during WAIT, then a stray done tick.
        push0(8'h50);
        wait_start("rw");
        tick();
        push0(8'h51);
        reset = 1'b0;
        #1;
        chk("rw_busy",   {31'd0, busy}, 32'd0);
        chk("rw_count",  {16'd0, sent_count}, 32'd0);
        chk("rw_start",  {31'd0, tx_start}, 32'd0);
        chk("rw_rd0",    {31'd0, rd0}, 32'd0);
        chk("rw_grant",  {31'd0, grant}, 32'd1);
        chk("rw_tx_din", {24'd0, tx_din}, 32'h00);
        tick();
        en = 1'b0;
        tick();
        reset = 1'b1;
        man_done = 1'b1;
        tick();
        man_done = 1'b0;
        act = 0;
        repeat (4) begin
            tick();
            if (rd0 || rd1 || tx_start || busy) act++;
        end
        chk("stray_activity", act, 0);
        chk("stray_count", {16'd0, sent_count}, 32'd0);
        en = 1'b1;
        #1;
        chk("fresh_rd0", {31'd0, rd0}, 32'd1);
        wait_start("fresh");
        chk("fresh_din", {24'd0, tx_din}, 32'h51);
        wait_idle("fresh");
        chk("fresh_count", {16'd0, sent_count}, 32'd1);

        // Counter wrap, observed on the 4-bit instance.
        tx_len = 1;
        for (int i = 0; i < 15; i++) begin
            push0(8'(8'h60 + i));
            wait_start("wrap");
            wait_idle("wrap");
        end
        chk("wrap_count16",  {16'd0, sent_count}, 32'd16);
        chk("wrap_narrow16", {28'd0, sent_count_w}, 32'd0);
        push0(8'h7F);
        wait_start("wrap_last");
        chk("wrap_last_din", {24'd0, tx_din}, 32'h7F);
        wait_idle("wrap_last");
        chk("wrap_count17",  {16'd0, sent_count}, 32'd17);
        chk("wrap_narrow17", {28'd0, sent_count_w}, 32'd1);

        chk("pop_rules", viol, 0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
